// File: rtl/move_controller.sv
// Move controller: turns debounced button presses into single-cycle board move commands.
// It tracks the 3x3 cursor, the player to move and a per-turn forfeit timeout.
module move_controller #(
   parameter logic [1:0]  FIRST_PLAYER = 2'b01,
   parameter int unsigned TIMEOUT_CYC  = 1000,
   parameter int unsigned CNT_W        = 10
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       game_state_i,
   input  logic       btn_up_i,
   input  logic       btn_down_i,
   input  logic       btn_left_i,
   input  logic       btn_right_i,
   input  logic       btn_confirm_i,
   input  logic [1:0] g0_i,
   input  logic [1:0] g1_i,
   input  logic [1:0] g2_i,
   input  logic [1:0] g3_i,
   input  logic [1:0] g4_i,
   input  logic [1:0] g5_i,
   input  logic [1:0] g6_i,
   input  logic [1:0] g7_i,
   input  logic [1:0] g8_i,
   output logic [1:0] mark_o,
   output logic [3:0] position_o,
   output logic [3:0] cursor_o,
   output logic [1:0] turn_o,
   output logic       reject_o,
   output logic       timeout_o
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_INPUT,
      COMMIT,
      SETTLE
   } state_e;

   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [3:0]       CENTER   = 4'd4;

   state_e           state_q, state_d;
   logic [1:0]       turn_q, turn_d;
   logic [3:0]       cursor_q, cursor_d;
   logic [3:0]       position_q, position_d;
   logic [1:0]       mark_q, mark_d;
   logic             reject_q, reject_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [4:0]       btnPrev_q;

   logic [4:0] btnNow;
   logic [4:0] btnEdge;
   logic       confirmHit, upHit, downHit, leftHit, rightHit;
   logic [1:0] cellAtCursor;
   logic       cellEmpty;
   logic [1:0] curRow, curCol;
   logic [3:0] cursorUp, cursorDown, cursorLeft, cursorRight;

   function automatic logic [1:0] otherPlayer(input logic [1:0] p);
      return (p == 2'b01) ? 2'b10 : 2'b01;
   endfunction

   // Bit order doubles as the action priority: confirm > up > down > left > right.
   assign btnNow  = {btn_confirm_i, btn_up_i, btn_down_i, btn_left_i, btn_right_i};
   assign btnEdge = btnNow & ~btnPrev_q;

   assign confirmHit = btnEdge[4];
   assign upHit      = btnEdge[3] & ~btnEdge[4];
   assign downHit    = btnEdge[2] & ~|btnEdge[4:3];
   assign leftHit    = btnEdge[1] & ~|btnEdge[4:2];
   assign rightHit   = btnEdge[0] & ~|btnEdge[4:1];

   always_comb begin
      cellAtCursor = 2'b11;
      curRow       = 2'd1;
      curCol       = 2'd1;
      case (cursor_q)
         4'd0: begin cellAtCursor = g0_i; curRow = 2'd0; curCol = 2'd0; end
         4'd1: begin cellAtCursor = g1_i; curRow = 2'd0; curCol = 2'd1; end
         4'd2: begin cellAtCursor = g2_i; curRow = 2'd0; curCol = 2'd2; end
         4'd3: begin cellAtCursor = g3_i; curRow = 2'd1; curCol = 2'd0; end
         4'd4: begin cellAtCursor = g4_i; curRow = 2'd1; curCol = 2'd1; end
         4'd5: begin cellAtCursor = g5_i; curRow = 2'd1; curCol = 2'd2; end
         4'd6: begin cellAtCursor = g6_i; curRow = 2'd2; curCol = 2'd0; end
         4'd7: begin cellAtCursor = g7_i; curRow = 2'd2; curCol = 2'd1; end
         4'd8: begin cellAtCursor = g8_i; curRow = 2'd2; curCol = 2'd2; end
         default: begin cellAtCursor = 2'b11; curRow = 2'd1; curCol = 2'd1; end
      endcase
   end

   assign cellEmpty = (cellAtCursor == 2'b00);

   // Neighbours wrap within the same row or column.
   always_comb begin
      cursorUp    = (curRow == 2'd0) ? cursor_q + 4'd6 : cursor_q - 4'd3;
      cursorDown  = (curRow == 2'd2) ? cursor_q - 4'd6 : cursor_q + 4'd3;
      cursorLeft  = (curCol == 2'd0) ? cursor_q + 4'd2 : cursor_q - 4'd1;
      cursorRight = (curCol == 2'd2) ? cursor_q - 4'd2 : cursor_q + 4'd1;
   end

   always_comb begin
      state_d    = state_q;
      turn_d     = turn_q;
      cursor_d   = cursor_q;
      position_d = position_q;
      mark_d     = 2'b00;
      reject_d   = 1'b0;
      timeout_d  = 1'b0;
      count_d    = count_q;

      case (state_q)
         IDLE: begin
            turn_d  = 2'b00;
            count_d = '0;
            if (game_state_i) begin
               state_d  = WAIT_INPUT;
               turn_d   = FIRST_PLAYER;
               cursor_d = CENTER;
            end
         end

         WAIT_INPUT: begin
            count_d = (count_q == TERM_CNT) ? count_q : count_q + CNT_W'(1);
            if (confirmHit && cellEmpty) begin
               state_d    = COMMIT;
               mark_d     = turn_q;
               position_d = cursor_q;
            end else begin
               if (confirmHit) begin
                  reject_d = 1'b1;
               end else if (upHit) begin
                  cursor_d = cursorUp;
               end else if (downHit) begin
                  cursor_d = cursorDown;
               end else if (leftHit) begin
                  cursor_d = cursorLeft;
               end else if (rightHit) begin
                  cursor_d = cursorRight;
               end
               if (count_q == TERM_CNT) begin
                  timeout_d = 1'b1;
                  turn_d    = otherPlayer(turn_q);
                  count_d   = '0;
               end
            end
         end

         COMMIT: begin
            state_d = SETTLE;
         end

         SETTLE: begin
            state_d = WAIT_INPUT;
            turn_d  = otherPlayer(turn_q);
            count_d = '0;
         end

         default: begin
            state_d = IDLE;
            turn_d  = 2'b00;
            count_d = '0;
         end
      endcase

      // Leaving the game overrides everything; a mark already on the output finishes its cycle.
      if (!game_state_i) begin
         state_d    = IDLE;
         turn_d     = 2'b00;
         count_d    = '0;
         mark_d     = 2'b00;
         reject_d   = 1'b0;
         timeout_d  = 1'b0;
         position_d = position_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         turn_q     <= 2'b00;
         cursor_q   <= CENTER;
         position_q <= 4'd0;
         mark_q     <= 2'b00;
         reject_q   <= 1'b0;
         timeout_q  <= 1'b0;
         count_q    <= '0;
         btnPrev_q  <= 5'b00000;
      end else begin
         state_q    <= state_d;
         turn_q     <= turn_d;
         cursor_q   <= cursor_d;
         position_q <= position_d;
         mark_q     <= mark_d;
         reject_q   <= reject_d;
         timeout_q  <= timeout_d;
         count_q    <= count_d;
         btnPrev_q  <= btnNow;
      end
   end

   assign mark_o     = mark_q;
   assign position_o = position_q;
   assign cursor_o   = cursor_q;
   assign turn_o     = turn_q;
   assign reject_o   = reject_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller with a short timeout so forfeits can be exercised.
module tb_move_controller;

   logic       clk;
   logic       rst;
   logic       gameState;
   logic       btnUp, btnDown, btnLeft, btnRight, btnConfirm;
   logic [1:0] g [9];
   logic [1:0] mark;
   logic [3:0] position;
   logic [3:0] cursor;
   logic [1:0] turn;
   logic       reject;
   logic       timeout;

   int vectors;
   int miscompares;

   move_controller #(
      .FIRST_PLAYER(2'b01),
      .TIMEOUT_CYC (8),
      .CNT_W       (4)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .game_state_i (gameState),
      .btn_up_i     (btnUp),
      .btn_down_i   (btnDown),
      .btn_left_i   (btnLeft),
      .btn_right_i  (btnRight),
      .btn_confirm_i(btnConfirm),
      .g0_i         (g[0]),
      .g1_i         (g[1]),
      .g2_i         (g[2]),
      .g3_i         (g[3]),
      .g4_i         (g[4]),
      .g5_i         (g[5]),
      .g6_i         (g[6]),
      .g7_i         (g[7]),
      .g8_i         (g[8]),
      .mark_o       (mark),
      .position_o   (position),
      .cursor_o     (cursor),
      .turn_o       (turn),
      .reject_o     (reject),
      .timeout_o    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic releaseButtons();
      btnUp = 1'b0; btnDown = 1'b0; btnLeft = 1'b0; btnRight = 1'b0; btnConfirm = 1'b0;
   endtask

   // Reset, then start a game; on return the first WAIT_INPUT cycle (counter 0) is current.
   task automatic restart();
      rst = 1'b0;
      gameState = 1'b0;
      releaseButtons();
      step();
      rst = 1'b1;
      gameState = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      gameState = 1'b0;
      releaseButtons();
      step();
      step();
      vectors++; if (mark !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_mark: got %0h expected 0", mark); end
      vectors++; if (position !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_position: got %0d expected 0", position); end
      vectors++; if (cursor !== 4'd4) begin miscompares++; $display("[TB] FAIL reset_cursor: got %0d expected 4", cursor); end
      vectors++; if (turn !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_turn: got %0h expected 0", turn); end
      vectors++; if (reject !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_reject: got %0b expected 0", reject); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_timeout: got %0b expected 0", timeout); end
   endtask

   task automatic test_basic_move();
      restart();
      vectors++; if (turn !== 2'b01) begin miscompares++; $display("[TB] FAIL basic_start_turn: got %0h expected 1", turn); end
      btnConfirm = 1'b1;
      step();
      vectors++; if (mark !== 2'b01) begin miscompares++; $display("[TB] FAIL basic_mark: got %0h expected 1", mark); end
      vectors++; if (position !== 4'd4) begin miscompares++; $display("[TB] FAIL basic_position: got %0d expected 4", position); end
      btnConfirm = 1'b0;
      step();
      vectors++; if (mark !== 2'b00) begin miscompares++; $display("[TB] FAIL basic_mark_single: got %0h expected 0", mark); end
      vectors++; if (turn !== 2'b01) begin miscompares++; $display("[TB] FAIL basic_turn_settle: got %0h expected 1", turn); end
      vectors++; if (position !== 4'd4) begin miscompares++; $display("[TB] FAIL basic_position_hold: got %0d expected 4", position); end
      step();
      vectors++; if (turn !== 2'b10) begin miscompares++; $display("[TB] FAIL basic_turn_swap: got %0h expected 2", turn); end
   endtask

   task automatic test_cursor();
      restart();
      btnUp = 1'b1; step(); btnUp = 1'b0; step();
      vectors++; if (cursor !== 4'd1) begin miscompares++; $display("[TB] FAIL cursor_up_mid: got %0d expected 1", cursor); end
      btnRight = 1'b1; step(); btnRight = 1'b0; step();
      vectors++; if (cursor !== 4'd2) begin miscompares++; $display("[TB] FAIL cursor_right_mid: got %0d expected 2", cursor); end
      btnRight = 1'b1; step(); btnRight = 1'b0;
      vectors++; if (cursor !== 4'd0) begin miscompares++; $display("[TB] FAIL cursor_right_wrap: got %0d expected 0", cursor); end
      step();
      btnUp = 1'b1; step();
      vectors++; if (cursor !== 4'd6) begin miscompares++; $display("[TB] FAIL cursor_up_wrap: got %0d expected 6", cursor); end
      for (int i = 0; i < 20; i++) begin
         step();
         vectors++; if (cursor !== 4'd6) begin miscompares++; $display("[TB] FAIL cursor_held_%0d: got %0d expected 6", i, cursor); end
      end
      btnUp = 1'b0; step();
      btnDown = 1'b1; step(); btnDown = 1'b0;
      vectors++; if (cursor !== 4'd0) begin miscompares++; $display("[TB] FAIL cursor_down_wrap: got %0d expected 0", cursor); end
      step();
      btnLeft = 1'b1; step(); btnLeft = 1'b0;
      vectors++; if (cursor !== 4'd2) begin miscompares++; $display("[TB] FAIL cursor_left_wrap: got %0d expected 2", cursor); end
      step();
      btnDown = 1'b1; btnLeft = 1'b1; step(); releaseButtons();
      vectors++; if (cursor !== 4'd5) begin miscompares++; $display("[TB] FAIL cursor_priority_down: got %0d expected 5", cursor); end
   endtask

   task automatic test_reject();
      restart();
      g[4] = 2'b01;
      btnConfirm = 1'b1;
      step();
      vectors++; if (reject !== 1'b1) begin miscompares++; $display("[TB] FAIL reject_pulse: got %0b expected 1", reject); end
      vectors++; if (mark !== 2'b00) begin miscompares++; $display("[TB] FAIL reject_no_mark: got %0h expected 0", mark); end
      vectors++; if (turn !== 2'b01) begin miscompares++; $display("[TB] FAIL reject_turn: got %0h expected 1", turn); end
      step();
      vectors++; if (reject !== 1'b0) begin miscompares++; $display("[TB] FAIL reject_one_cycle: got %0b expected 0", reject); end
      vectors++; if (mark !== 2'b00) begin miscompares++; $display("[TB] FAIL reject_no_mark_late: got %0h expected 0", mark); end
      btnConfirm = 1'b0;
      g[4] = 2'b00;
   endtask

   // Reject at counter 1 must not restart the count: forfeit still lands on cycle 8.
   task automatic test_timeout();
      logic       expTmo;
      logic [1:0] expTurn;
      restart();
      for (int c = 1; c <= 16; c++) begin
         btnConfirm = (c == 1) && (g[4] == 2'b00) ? 1'b0 : 1'b0;
         step();
         expTmo  = (c == 8) || (c == 16);
         expTurn = (c < 8) ? 2'b01 : ((c < 16) ? 2'b10 : 2'b01);
         vectors++; if (timeout !== expTmo) begin miscompares++; $display("[TB] FAIL timeout_pulse_c%0d: got %0b expected %0b", c, timeout, expTmo); end
         vectors++; if (turn !== expTurn) begin miscompares++; $display("[TB] FAIL timeout_turn_c%0d: got %0h expected %0h", c, turn, expTurn); end
         vectors++; if (mark !== 2'b00) begin miscompares++; $display("[TB] FAIL timeout_mark_c%0d: got %0h expected 0", c, mark); end
      end
      restart();
      g[4] = 2'b10;
      step();
      btnConfirm = 1'b1;
      step();
      btnConfirm = 1'b0;
      for (int c = 3; c <= 8; c++) step();
      vectors++; if (timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_after_reject: got %0b expected 1", timeout); end
      g[4] = 2'b00;
   endtask

   task automatic test_back_to_back();
      restart();
      btnConfirm = 1'b1; btnRight = 1'b1;
      step();
      vectors++; if (mark !== 2'b01) begin miscompares++; $display("[TB] FAIL combo_mark: got %0h expected 1", mark); end
      vectors++; if (position !== 4'd4) begin miscompares++; $display("[TB] FAIL combo_position: got %0d expected 4", position); end
      releaseButtons();
      step(); step();
      vectors++; if (cursor !== 4'd4) begin miscompares++; $display("[TB] FAIL combo_cursor: got %0d expected 4", cursor); end
      vectors++; if (turn !== 2'b10) begin miscompares++; $display("[TB] FAIL combo_turn: got %0h expected 2", turn); end

      restart();
      for (int c = 1; c <= 7; c++) step();
      btnConfirm = 1'b1;
      step();
      vectors++; if (mark !== 2'b01) begin miscompares++; $display("[TB] FAIL term_mark: got %0h expected 1", mark); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL term_no_timeout: got %0b expected 0", timeout); end
      vectors++; if (turn !== 2'b01) begin miscompares++; $display("[TB] FAIL term_turn_commit: got %0h expected 1", turn); end
      btnConfirm = 1'b0;
      step();
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL term_no_timeout_settle: got %0b expected 0", timeout); end
      step();
      vectors++; if (turn !== 2'b10) begin miscompares++; $display("[TB] FAIL term_turn_next: got %0h expected 2", turn); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL term_no_timeout_next: got %0b expected 0", timeout); end
   endtask

   task automatic test_abort();
      restart();
      btnRight = 1'b1; step(); btnRight = 1'b0;
      vectors++; if (cursor !== 4'd5) begin miscompares++; $display("[TB] FAIL abort_cursor_move: got %0d expected 5", cursor); end
      gameState = 1'b0;
      step();
      vectors++; if (turn !== 2'b00) begin miscompares++; $display("[TB] FAIL abort_turn: got %0h expected 0", turn); end
      vectors++; if (mark !== 2'b00) begin miscompares++; $display("[TB] FAIL abort_mark: got %0h expected 0", mark); end
      gameState = 1'b1;
      step();
      vectors++; if (turn !== 2'b01) begin miscompares++; $display("[TB] FAIL abort_restart_turn: got %0h expected 1", turn); end
      vectors++; if (cursor !== 4'd4) begin miscompares++; $display("[TB] FAIL abort_restart_cursor: got %0d expected 4", cursor); end

      restart();
      btnRight = 1'b1; step(); btnRight = 1'b0;
      btnConfirm = 1'b1; step(); btnConfirm = 1'b0;
      vectors++; if (position !== 4'd5) begin miscompares++; $display("[TB] FAIL settle_pre_position: got %0d expected 5", position); end
      step();
      rst = 1'b0;
      step();
      vectors++; if (mark !== 2'b00) begin miscompares++; $display("[TB] FAIL settle_rst_mark: got %0h expected 0", mark); end
      vectors++; if (position !== 4'd0) begin miscompares++; $display("[TB] FAIL settle_rst_position: got %0d expected 0", position); end
      vectors++; if (cursor !== 4'd4) begin miscompares++; $display("[TB] FAIL settle_rst_cursor: got %0d expected 4", cursor); end
      vectors++; if (turn !== 2'b00) begin miscompares++; $display("[TB] FAIL settle_rst_turn: got %0h expected 0", turn); end
      vectors++; if (reject !== 1'b0) begin miscompares++; $display("[TB] FAIL settle_rst_reject: got %0b expected 0", reject); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL settle_rst_timeout: got %0b expected 0", timeout); end
      rst = 1'b1;
      step();
      vectors++; if (turn !== 2'b01) begin miscompares++; $display("[TB] FAIL settle_rst_restart: got %0h expected 1", turn); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      gameState   = 1'b0;
      releaseButtons();
      for (int i = 0; i < 9; i++) g[i] = 2'b00;

      test_reset();
      test_basic_move();
      test_cursor();
      test_reject();
      test_timeout();
      test_back_to_back();
      test_abort();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
